// File: rtl/fifo_wr_packer.sv
// Write-side packer for the dual-clock FIFO: gathers RATIO narrow beats into one wide word.
// Optional partial-word idle flush is enabled by defining PACK_TIMEOUT_EN.
module fifo_wr_packer #(
    parameter int IN_W    = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       w_clk,
    input  logic                       w_rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_W-1:0]            s_data,
    input  logic                       s_last,
    output logic                       w_en,
    output logic [IN_W*RATIO-1:0]      w_data,
    output logic [RATIO-1:0]           w_keep,
    output logic                       w_last,
    input  logic                       full,
    output logic [$clog2(RATIO+1)-1:0] pack_lvl
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LW = $clog2(RATIO+1);
    localparam int DW = IN_W * RATIO;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     r_acc;
    logic [DW-1:0]     r_word;
    logic [DW-1:0]     w_nextWord;
    logic [RATIO-1:0]  r_keep;
    logic [RATIO-1:0]  w_nextKeep;
    logic              r_last;
    logic              w_nextLast;
    logic              w_accept;
    logic              w_write;
    logic              w_complete;
    logic              w_flush;
    logic              w_load;
    logic              w_lastLane;
    logic              w_readyBase;

    assign w_write     = (r_state == HOLD) && !full;
    assign w_readyBase = (r_state == EMPTY) || !full;
    assign w_lastLane  = (r_cnt == CW'(RATIO - 1));

`ifdef PACK_TIMEOUT_EN
    logic [15:0] r_idle;

    assign w_flush = (r_cnt != '0) && (int'(r_idle) >= TIMEOUT) && w_readyBase;
    // A beat offered on the flush cycle must wait so it lands in the next word.
    assign s_ready = w_rst_n && w_readyBase && !w_flush;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_idle <= '0;
        end else if (w_accept || (r_cnt == '0) || w_flush) begin
            r_idle <= '0;
        end else if (r_idle != 16'hFFFF) begin
            r_idle <= r_idle + 16'd1;
        end
    end
`else
    assign w_flush = 1'b0;
    assign s_ready = w_rst_n && w_readyBase;
`endif

    assign w_accept   = s_valid && s_ready;
    assign w_complete = w_accept && (w_lastLane || s_last);
    assign w_load     = w_complete || w_flush;

    // Untouched accumulator lanes are always zero, so unfilled lanes come out zero.
    always_comb begin
        w_nextWord = r_acc;
        w_nextKeep = '0;
        w_nextLast = 1'b0;
        for (int i = 0; i < RATIO; i++) begin
            if (w_complete) begin
                w_nextKeep[i] = (i <= int'(r_cnt));
            end else begin
                w_nextKeep[i] = (i < int'(r_cnt));
            end
        end
        if (w_complete) begin
            w_nextWord[int'(r_cnt)*IN_W +: IN_W] = s_data;
            w_nextLast = s_last;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY:   if (w_load) w_nextState = HOLD;
            HOLD:    if (w_load) w_nextState = HOLD;
                     else if (w_write) w_nextState = EMPTY;
            default: w_nextState = EMPTY;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc[int'(r_cnt)*IN_W +: IN_W] <= s_data;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_word <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
        end else if (w_load) begin
            r_word <= w_nextWord;
            r_keep <= w_nextKeep;
            r_last <= w_nextLast;
        end
    end

    assign w_en     = (r_state == HOLD);
    assign w_data   = r_word;
    assign w_keep   = r_keep;
    assign w_last   = r_last;
    assign pack_lvl = LW'(r_cnt);

endmodule
